// File: rtl/kypd_pkg.sv
// Shared constants, key type and scan decoder for the 4x4 keypad scanner.
// Optional build macro KYPD_REPEAT_EN is consumed by kypd_scanner.
package kypd_pkg;

   localparam int KEY_W = 4;
   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int COL_W = $clog2(COLS);

   typedef struct packed {
      logic             present;
      logic [KEY_W-1:0] code;
   } key_t;

   localparam key_t KEY_NONE = '{present: 1'b0, code: '0};

   // Indexed {row,col}; entry 0 is row 0 / col 0.
   localparam logic [ROWS*COLS-1:0][KEY_W-1:0] KEY_MAP = {
      4'hD, 4'hE, 4'hF, 4'h0,
      4'hC, 4'h9, 4'h8, 4'h7,
      4'hB, 4'h6, 4'h5, 4'h4,
      4'hA, 4'h3, 4'h2, 4'h1
   };

   // Scan bits are laid out [col*ROWS + row]; anything but a single hit is no key.
   function automatic key_t decode_scan(input logic [ROWS*COLS-1:0] bits);
      key_t k;
      int   hits;
      k    = KEY_NONE;
      hits = 0;
      for (int i = 0; i < ROWS*COLS; i++) begin
         if (bits[i]) begin
            hits++;
            k.present = 1'b1;
            k.code    = KEY_MAP[{i[1:0], i[3:2]}];
         end
      end
      if (hits != 1) k = KEY_NONE;
      return k;
   endfunction

endpackage

// File: rtl/kypd_debouncer.sv
// Per-scan debounce: a result must repeat DEBOUNCE_SCANS times before it
// becomes the stable key; a change to a real key pulses press.
module kypd_debouncer
   import kypd_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4
)(
   input  logic clk,
   input  logic rst,
   input  logic scan_done,
   input  key_t scan_key,
   output key_t stable_key,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

   key_t          prev_key;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = cnt;
      if (scan_done) begin
         if (scan_key == prev_key)
            cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
         else
            cnt_nxt = CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_key   <= KEY_NONE;
         cnt        <= '0;
         stable_key <= KEY_NONE;
         press      <= 1'b0;
      end else begin
         press <= 1'b0;
         cnt   <= cnt_nxt;
         if (scan_done) begin
            prev_key <= scan_key;
            if (cnt_nxt == CNT_MAX && scan_key != stable_key) begin
               stable_key <= scan_key;
               press      <= scan_key.present;
            end
         end
      end
   end

endmodule

// File: rtl/kypd_scanner.sv
// 4x4 keypad column scanner with debounce and valid/ready key events.
// Define KYPD_REPEAT_EN to add auto-repeat events while a key stays held.
module kypd_scanner
   import kypd_pkg::*;
#(
   parameter int SCAN_CYCLES        = 100000,
   parameter int DEBOUNCE_SCANS     = 4,
   parameter int REPEAT_DELAY_SCANS = 125,
   parameter int REPEAT_SCANS       = 25
)(
   input  logic             OSC_100MHz,
   input  logic             RST,
   output logic [COLS-1:0]  KYPD_COL,
   input  logic [ROWS-1:0]  KYPD_ROW,
   output logic [KEY_W-1:0] KEY_CODE,
   output logic             KEY_VALID,
   input  logic             KEY_READY,
   output logic             KEY_HELD,
   output logic             KEY_OVERRUN
);

   localparam int CNT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);

   logic [ROWS-1:0]            row_meta;
   logic [ROWS-1:0]            row_sync;
   logic [CNT_W-1:0]           dwell;
   logic [COL_W-1:0]           col;
   logic [COLS-1:0][ROWS-1:0]  scan_bits;
   logic                       scan_done;
   key_t                       scan_key;
   key_t                       stable_key;
   logic                       press;
   logic                       rpt_evt;
   logic                       evt;

   // Rows are sampled at the end of each column's dwell so the pins have settled.
   always_ff @(posedge OSC_100MHz or posedge RST) begin
      if (RST) begin
         row_meta  <= '1;
         row_sync  <= '1;
         dwell     <= '0;
         col       <= '0;
         scan_bits <= '0;
         scan_done <= 1'b0;
      end else begin
         row_meta  <= KYPD_ROW;
         row_sync  <= row_meta;
         scan_done <= 1'b0;
         if (dwell == DWELL_LAST) begin
            dwell          <= '0;
            scan_bits[col] <= ~row_sync;
            col            <= col + 1'b1;
            scan_done      <= (col == COL_LAST);
         end else begin
            dwell <= dwell + 1'b1;
         end
      end
   end

   assign KYPD_COL = ~(COLS'(1) << col);
   assign scan_key = decode_scan(scan_bits);

   kypd_debouncer #(
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
   ) u_debouncer (
      .clk        (OSC_100MHz),
      .rst        (RST),
      .scan_done  (scan_done),
      .scan_key   (scan_key),
      .stable_key (stable_key),
      .press      (press)
   );

`ifdef KYPD_REPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY_SCANS > REPEAT_SCANS) ? REPEAT_DELAY_SCANS : REPEAT_SCANS;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   logic [RPT_W-1:0] rpt_cnt;
   logic [RPT_W-1:0] rpt_target;
   logic             rpt_first;

   assign rpt_target = rpt_first ? RPT_W'(REPEAT_DELAY_SCANS) : RPT_W'(REPEAT_SCANS);

   // Counts whole scans since the last press or repeat while the key stays down.
   always_ff @(posedge OSC_100MHz or posedge RST) begin
      if (RST) begin
         rpt_cnt   <= '0;
         rpt_first <= 1'b1;
         rpt_evt   <= 1'b0;
      end else begin
         rpt_evt <= 1'b0;
         if (press || !stable_key.present) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
         end else if (scan_done) begin
            if (rpt_cnt + 1'b1 == rpt_target) begin
               rpt_evt   <= 1'b1;
               rpt_cnt   <= '0;
               rpt_first <= 1'b0;
            end else begin
               rpt_cnt <= rpt_cnt + 1'b1;
            end
         end
      end
   end
`else
   assign rpt_evt = 1'b0;
`endif

   assign evt = press | rpt_evt;

   // A completed handshake frees the slot, so a same-cycle event is taken as new.
   always_ff @(posedge OSC_100MHz or posedge RST) begin
      if (RST) begin
         KEY_VALID   <= 1'b0;
         KEY_CODE    <= '0;
         KEY_OVERRUN <= 1'b0;
      end else begin
         if (evt && (!KEY_VALID || KEY_READY)) begin
            KEY_VALID <= 1'b1;
            KEY_CODE  <= stable_key.code;
         end else if (KEY_VALID && KEY_READY) begin
            KEY_VALID <= 1'b0;
         end
         if (KEY_VALID && KEY_READY)
            KEY_OVERRUN <= 1'b0;
         else if (evt && KEY_VALID)
            KEY_OVERRUN <= 1'b1;
      end
   end

   assign KEY_HELD = stable_key.present;

endmodule
